// File: rtl/program_counter_nested.sv
// Instruction fetch address generator: sequential advance bounded by the loaded cache window,
// plus interrupt jump / return through a return-address stack. Acks and redirect are registered (1 cycle).
module program_counter_nested #(
    parameter int ADDR_WIDTH_MEM  = 16,
    parameter int ISA_DEPTH       = 64,
    parameter int TOTAL_ISA_DEPTH = 128,
    parameter int DDR_ADDR_WIDTH  = 28,
    parameter int STACK_DEPTH     = 4,
    parameter int JMP_SHIFT       = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ins_fire,
    input  logic                               ins_cache_rdy,
    input  logic [9:0]                         load_times,
    input  logic                               int_req,
    input  logic [DDR_ADDR_WIDTH-1:0]          int_vector,
    input  logic                               ret_req,
    output logic [ADDR_WIDTH_MEM-1:0]          addr_ins,
    output logic [ADDR_WIDTH_MEM-1:0]          addr_cur_ins,
    output logic                               int_ack,
    output logic                               ret_ack,
    output logic                               redirect,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
    output logic                               ovf_err,
    output logic                               unf_err,
    output logic                               done
);
    localparam int SW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int LW = ADDR_WIDTH_MEM + 10;

    typedef enum logic [1:0] {START, RUN, REDIRECT, DONE} state_t;

    state_t                                     state_q, state_d;
    logic [ADDR_WIDTH_MEM-1:0]                  addr_ins_q, addr_ins_d;
    logic [ADDR_WIDTH_MEM-1:0]                  addr_cur_q, addr_cur_d;
    logic                                       int_ack_q, int_ack_d;
    logic                                       ret_ack_q, ret_ack_d;
    logic                                       redirect_q, redirect_d;
    logic [SW-1:0]                              level_q, level_d;
    logic                                       ovf_q, ovf_d;
    logic                                       unf_q, unf_d;
    logic                                       done_q, done_d;
    logic [STACK_DEPTH-1:0][ADDR_WIDTH_MEM-1:0] stack_q, stack_d;

    logic [LW-1:0]             limit;
    logic [ADDR_WIDTH_MEM-1:0] addr_inc;
    logic                      stack_full;
    logic                      stack_empty;
    logic                      adv_ok;

    // Window limit is formed at full width so large load_times never wraps.
    assign limit       = LW'(ISA_DEPTH) * LW'(load_times);
    assign addr_inc    = addr_ins_q + 1'b1;
    assign stack_full  = (level_q == SW'(STACK_DEPTH));
    assign stack_empty = (level_q == '0);
    assign adv_ok      = ins_fire && ins_cache_rdy
                      && (LW'(addr_ins_q) < LW'(TOTAL_ISA_DEPTH))
                      && (LW'(addr_ins_q) != limit);

    always_comb begin
        state_d    = state_q;
        addr_ins_d = addr_ins_q;
        addr_cur_d = addr_cur_q;
        int_ack_d  = 1'b0;
        ret_ack_d  = 1'b0;
        redirect_d = 1'b0;
        level_d    = level_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        done_d     = done_q;
        stack_d    = stack_q;
        case (state_q)
            START: state_d = RUN;
            RUN, DONE: begin
                if (int_req) begin
                    int_ack_d = 1'b1;
                    if (!stack_full) begin
                        stack_d[IW'(level_q)] = addr_ins_q;
                        level_d    = level_q + 1'b1;
                        addr_ins_d = int_vector[JMP_SHIFT +: ADDR_WIDTH_MEM];
                        redirect_d = 1'b1;
                        done_d     = 1'b0;
                        state_d    = REDIRECT;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (state_q == RUN && ret_req) begin
                    ret_ack_d = 1'b1;
                    if (!stack_empty) begin
                        addr_ins_d = stack_q[IW'(level_q - 1'b1)];
                        level_d    = level_q - 1'b1;
                        redirect_d = 1'b1;
                        state_d    = REDIRECT;
                    end else begin
                        unf_d = 1'b1;
                    end
                end else if (state_q == RUN && adv_ok) begin
                    addr_ins_d = addr_inc;
                    addr_cur_d = addr_inc;
                    if (LW'(addr_inc) == LW'(TOTAL_ISA_DEPTH)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            // The cache refetches this cycle; requests are not resampled here.
            REDIRECT: state_d = RUN;
            default:  state_d = START;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= START;
            addr_ins_q <= '0;
            addr_cur_q <= '0;
            int_ack_q  <= 1'b0;
            ret_ack_q  <= 1'b0;
            redirect_q <= 1'b0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            done_q     <= 1'b0;
            stack_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_ins_q <= addr_ins_d;
            addr_cur_q <= addr_cur_d;
            int_ack_q  <= int_ack_d;
            ret_ack_q  <= ret_ack_d;
            redirect_q <= redirect_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            done_q     <= done_d;
            stack_q    <= stack_d;
        end
    end

    assign addr_ins     = addr_ins_q;
    assign addr_cur_ins = addr_cur_q;
    assign int_ack      = int_ack_q;
    assign ret_ack      = ret_ack_q;
    assign redirect     = redirect_q;
    assign stack_level  = level_q;
    assign ovf_err      = ovf_q;
    assign unf_err      = unf_q;
    assign done         = done_q;
endmodule

// File: tb/tb_program_counter_nested.sv
// Directed bench for program_counter_nested: advance, window stall, jumps/returns, nesting errors, async reset.
module tb_program_counter_nested;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ins_fire = 1'b0;
    logic        ins_cache_rdy = 1'b0;
    logic [9:0]  load_times = '0;
    logic        int_req = 1'b0;
    logic [27:0] int_vector = '0;
    logic        ret_req = 1'b0;
    logic [15:0] addr_ins;
    logic [15:0] addr_cur_ins;
    logic        int_ack;
    logic        ret_ack;
    logic        redirect;
    logic [2:0]  stack_level;
    logic        ovf_err;
    logic        unf_err;
    logic        done;

    int errors = 0;
    int checks = 0;

    program_counter_nested dut (
        .clk(clk), .rst(rst), .ins_fire(ins_fire), .ins_cache_rdy(ins_cache_rdy),
        .load_times(load_times), .int_req(int_req), .int_vector(int_vector), .ret_req(ret_req),
        .addr_ins(addr_ins), .addr_cur_ins(addr_cur_ins), .int_ack(int_ack), .ret_ack(ret_ack),
        .redirect(redirect), .stack_level(stack_level), .ovf_err(ovf_err), .unf_err(unf_err),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ins_fire = 1'b0; ins_cache_rdy = 1'b0; load_times = '0;
        int_req = 1'b0; int_vector = '0; ret_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (addr_ins !== 16'd0) begin errors++; $display("FAIL reset_addr_ins: got %0d want 0", addr_ins); end
        checks++; if (addr_cur_ins !== 16'd0) begin errors++; $display("FAIL reset_addr_cur: got %0d want 0", addr_cur_ins); end
        checks++; if ({int_ack, ret_ack, redirect, ovf_err, unf_err, done} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 000000", {int_ack, ret_ack, redirect, ovf_err, unf_err, done}); end
        checks++; if (stack_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", stack_level); end
        do_reset();
    endtask

    task automatic test_basic_advance();
        load_times = 10'd2; ins_fire = 1'b1; ins_cache_rdy = 1'b1;
        tick();
        checks++; if (addr_ins !== 16'd0) begin errors++; $display("FAIL start_addr: got %0d want 0", addr_ins); end
        for (int i = 1; i <= 128; i++) begin
            tick();
            checks++; if (addr_ins !== 16'(i)) begin errors++; $display("FAIL adv_addr: got %0d want %0d", addr_ins, i); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL adv_done: got %b want 1", done); end
        tick(); tick();
        checks++; if (addr_ins !== 16'd128) begin errors++; $display("FAIL done_hold: got %0d want 128", addr_ins); end
        checks++; if (addr_cur_ins !== 16'd128) begin errors++; $display("FAIL done_cur: got %0d want 128", addr_cur_ins); end
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        checks++; if (ret_ack !== 1'b0 || unf_err !== 1'b0) begin errors++;
            $display("FAIL done_ret_ignored: got ack=%b unf=%b want 0 0", ret_ack, unf_err); end
        int_req = 1'b1; int_vector = 28'h80;
        tick();
        int_req = 1'b0;
        checks++; if (int_ack !== 1'b1 || addr_ins !== 16'd16 || done !== 1'b0 || stack_level !== 3'd1) begin errors++;
            $display("FAIL done_int: got ack=%b addr=%0d done=%b lvl=%0d want 1 16 0 1", int_ack, addr_ins, done, stack_level); end
        tick();
        checks++; if (addr_ins !== 16'd16 || redirect !== 1'b0) begin errors++;
            $display("FAIL redirect_no_adv: got addr=%0d redir=%b want 16 0", addr_ins, redirect); end
        tick();
        checks++; if (addr_ins !== 16'd17) begin errors++; $display("FAIL post_redirect_adv: got %0d want 17", addr_ins); end
    endtask

    task automatic test_window_stall();
        do_reset();
        load_times = 10'd0; ins_fire = 1'b1; ins_cache_rdy = 1'b1;
        tick(); tick(); tick(); tick();
        checks++; if (addr_ins !== 16'd0) begin errors++; $display("FAIL zero_limit: got %0d want 0", addr_ins); end
        load_times = 10'd1;
        for (int i = 0; i < 64; i++) tick();
        checks++; if (addr_ins !== 16'd64) begin errors++; $display("FAIL window_reach: got %0d want 64", addr_ins); end
        tick(); tick(); tick();
        checks++; if (addr_ins !== 16'd64 || done !== 1'b0) begin errors++;
            $display("FAIL window_stall: got addr=%0d done=%b want 64 0", addr_ins, done); end
        load_times = 10'd2; ins_cache_rdy = 1'b0;
        tick();
        checks++; if (addr_ins !== 16'd64) begin errors++; $display("FAIL cache_not_rdy: got %0d want 64", addr_ins); end
        ins_cache_rdy = 1'b1;
        tick();
        checks++; if (addr_ins !== 16'd65 || addr_cur_ins !== 16'd65) begin errors++;
            $display("FAIL window_resume: got addr=%0d cur=%0d want 65 65", addr_ins, addr_cur_ins); end
    endtask

    task automatic test_int_ret();
        do_reset();
        load_times = 10'd2; ins_fire = 1'b1; ins_cache_rdy = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        checks++; if (addr_ins !== 16'd10) begin errors++; $display("FAIL pre_int_addr: got %0d want 10", addr_ins); end
        int_req = 1'b1; int_vector = 28'h200; ins_fire = 1'b0;
        tick();
        int_req = 1'b0;
        checks++; if (addr_ins !== 16'd64 || int_ack !== 1'b1 || redirect !== 1'b1 || stack_level !== 3'd1) begin errors++;
            $display("FAIL int_jump: got addr=%0d ack=%b redir=%b lvl=%0d want 64 1 1 1", addr_ins, int_ack, redirect, stack_level); end
        checks++; if (addr_cur_ins !== 16'd10) begin errors++; $display("FAIL int_cur_hold: got %0d want 10", addr_cur_ins); end
        tick();
        checks++; if (int_ack !== 1'b0 || redirect !== 1'b0) begin errors++;
            $display("FAIL int_pulse: got ack=%b redir=%b want 0 0", int_ack, redirect); end
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        checks++; if (addr_ins !== 16'd10 || ret_ack !== 1'b1 || redirect !== 1'b1 || stack_level !== 3'd0) begin errors++;
            $display("FAIL ret_jump: got addr=%0d ack=%b redir=%b lvl=%0d want 10 1 1 0", addr_ins, ret_ack, redirect, stack_level); end
        tick();
        checks++; if (ret_ack !== 1'b0 || redirect !== 1'b0) begin errors++;
            $display("FAIL ret_pulse: got ack=%b redir=%b want 0 0", ret_ack, redirect); end
    endtask

    task automatic test_overflow();
        logic [27:0] vec [5];
        logic [15:0] tgt [5];
        logic [15:0] back [4];
        vec = '{28'h0800040, 28'h80, 28'hC0, 28'h100, 28'h140};
        tgt = '{16'd8, 16'd16, 16'd24, 16'd32, 16'd40};
        back = '{16'd24, 16'd16, 16'd8, 16'd0};
        do_reset();
        load_times = 10'd2;
        tick();
        for (int k = 0; k < 4; k++) begin
            int_req = 1'b1; int_vector = vec[k];
            tick();
            int_req = 1'b0;
            checks++; if (addr_ins !== tgt[k] || stack_level !== 3'(k + 1) || int_ack !== 1'b1) begin errors++;
                $display("FAIL nest_int%0d: got addr=%0d lvl=%0d ack=%b want %0d %0d 1", k, addr_ins, stack_level, int_ack, tgt[k], k + 1); end
            tick();
        end
        int_req = 1'b1; int_vector = vec[4];
        tick();
        int_req = 1'b0;
        checks++; if (int_ack !== 1'b1 || ovf_err !== 1'b1 || addr_ins !== 16'd32 || stack_level !== 3'd4 || redirect !== 1'b0) begin errors++;
            $display("FAIL overflow: got ack=%b ovf=%b addr=%0d lvl=%0d redir=%b want 1 1 32 4 0", int_ack, ovf_err, addr_ins, stack_level, redirect); end
        tick();
        for (int k = 0; k < 4; k++) begin
            ret_req = 1'b1;
            tick();
            ret_req = 1'b0;
            checks++; if (addr_ins !== back[k] || stack_level !== 3'(3 - k) || ret_ack !== 1'b1) begin errors++;
                $display("FAIL nest_ret%0d: got addr=%0d lvl=%0d ack=%b want %0d %0d 1", k, addr_ins, stack_level, ret_ack, back[k], 3 - k); end
            tick();
        end
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf_err); end
    endtask

    task automatic test_underflow_collision();
        do_reset();
        load_times = 10'd2;
        tick();
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        checks++; if (ret_ack !== 1'b1 || unf_err !== 1'b1 || addr_ins !== 16'd0 || redirect !== 1'b0) begin errors++;
            $display("FAIL underflow: got ack=%b unf=%b addr=%0d redir=%b want 1 1 0 0", ret_ack, unf_err, addr_ins, redirect); end
        tick();
        checks++; if (ret_ack !== 1'b0 || unf_err !== 1'b1) begin errors++;
            $display("FAIL unf_sticky: got ack=%b unf=%b want 0 1", ret_ack, unf_err); end
        int_req = 1'b1; ret_req = 1'b1; int_vector = 28'h100;
        tick();
        int_req = 1'b0;
        checks++; if (int_ack !== 1'b1 || ret_ack !== 1'b0 || addr_ins !== 16'd32 || stack_level !== 3'd1) begin errors++;
            $display("FAIL collide_int: got iack=%b rack=%b addr=%0d lvl=%0d want 1 0 32 1", int_ack, ret_ack, addr_ins, stack_level); end
        tick();
        checks++; if (ret_ack !== 1'b0 || addr_ins !== 16'd32) begin errors++;
            $display("FAIL collide_wait: got rack=%b addr=%0d want 0 32", ret_ack, addr_ins); end
        tick();
        ret_req = 1'b0;
        checks++; if (ret_ack !== 1'b1 || addr_ins !== 16'd0 || stack_level !== 3'd0) begin errors++;
            $display("FAIL collide_ret: got rack=%b addr=%0d lvl=%0d want 1 0 0", ret_ack, addr_ins, stack_level); end
        tick();
    endtask

    task automatic test_reset_mid();
        int_req = 1'b1; int_vector = 28'h40;
        tick();
        int_req = 1'b0;
        tick();
        int_req = 1'b1; int_vector = 28'h80;
        tick();
        int_req = 1'b0;
        checks++; if (stack_level !== 3'd2 || redirect !== 1'b1) begin errors++;
            $display("FAIL pre_reset: got lvl=%0d redir=%b want 2 1", stack_level, redirect); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (addr_ins !== 16'd0 || addr_cur_ins !== 16'd0 || stack_level !== 3'd0) begin errors++;
            $display("FAIL async_reset_addr: got addr=%0d cur=%0d lvl=%0d want 0 0 0", addr_ins, addr_cur_ins, stack_level); end
        checks++; if ({int_ack, ret_ack, redirect, ovf_err, unf_err, done} !== 6'b0) begin errors++;
            $display("FAIL async_reset_flags: got %b want 000000", {int_ack, ret_ack, redirect, ovf_err, unf_err, done}); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_times = 10'd2; ins_fire = 1'b1; ins_cache_rdy = 1'b1;
        tick();
        checks++; if (addr_ins !== 16'd0) begin errors++; $display("FAIL restart_start: got %0d want 0", addr_ins); end
        tick();
        checks++; if (addr_ins !== 16'd1) begin errors++; $display("FAIL restart_run: got %0d want 1", addr_ins); end
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        checks++; if (unf_err !== 1'b1 || addr_ins !== 16'd1 || stack_level !== 3'd0) begin errors++;
            $display("FAIL stack_discarded: got unf=%b addr=%0d lvl=%0d want 1 1 0", unf_err, addr_ins, stack_level); end
    endtask

    initial begin
        test_reset();
        test_basic_advance();
        test_window_stall();
        test_int_ret();
        test_overflow();
        test_underflow_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
